// File: rtl/pc_redirect_fetch_if.sv
// Fetch-stage bus: hazard/redirect controls into the PC generator, fetch PC and flush status back out.
// The master modport belongs to the pipeline control side; the slave modport belongs to pc_redirect_fetch.
interface pc_redirect_fetch_if #(
    parameter int XLEN = 32
);
    logic            stall;
    logic            br_taken;
    logic [XLEN-1:0] br_target;
    logic [XLEN-1:0] pc_out;
    logic            valid_out;
    logic            flush_out;
    logic            misalign_out;

    modport master (
        output stall,
        output br_taken,
        output br_target,
        input  pc_out,
        input  valid_out,
        input  flush_out,
        input  misalign_out
    );

    modport slave (
        input  stall,
        input  br_taken,
        input  br_target,
        output pc_out,
        output valid_out,
        output flush_out,
        output misalign_out
    );
endinterface

// File: rtl/pc_redirect_fetch.sv
// Fetch-stage PC generator: +4 sequencing, stall hold, execute-stage redirect with a FLUSH_DEPTH-cycle flush train.
// Optional macro PC_MISALIGN_TRAP_EN steers misaligned redirect targets to TRAP_VECTOR and pulses misalign_out.
module pc_redirect_fetch #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              FLUSH_DEPTH  = 2
`ifdef PC_MISALIGN_TRAP_EN
    ,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100)
`endif
) (
    input  logic               clk,
    input  logic               rst,
    pc_redirect_fetch_if.slave fetch_if
);

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        FLUSH
    } state_e;

    localparam logic [2:0] FLUSH_CNT_INIT = 3'(FLUSH_DEPTH);

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            valid_q, valid_d;
    logic            flush_q, flush_d;
    logic [2:0]      flushCnt_q, flushCnt_d;
    logic [XLEN-1:0] redirectPc;

`ifdef PC_MISALIGN_TRAP_EN
    logic misalign_q, misalign_d;
    logic targetMisaligned;

    assign targetMisaligned = (fetch_if.br_target[1:0] != 2'b00);
    assign redirectPc       = targetMisaligned ? TRAP_VECTOR : fetch_if.br_target;

    // One-cycle pulse, registered on the same edge that loads the trap PC.
    always_comb begin
        misalign_d = 1'b0;
        if (state_q != BOOT && fetch_if.br_taken && targetMisaligned) begin
            misalign_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign fetch_if.misalign_out = misalign_q;
`else
    assign redirectPc            = fetch_if.br_target;
    assign fetch_if.misalign_out = 1'b0;
`endif

    // Redirect outranks stall; the flush counter keeps running through stalls.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        valid_d    = valid_q;
        flush_d    = flush_q;
        flushCnt_d = flushCnt_q;
        case (state_q)
            BOOT: begin
                state_d = RUN;
                valid_d = 1'b1;
            end
            RUN, FLUSH: begin
                if (fetch_if.br_taken) begin
                    pc_d       = redirectPc;
                    valid_d    = 1'b1;
                    flushCnt_d = FLUSH_CNT_INIT;
                    flush_d    = 1'b1;
                    state_d    = FLUSH;
                end else begin
                    if (!fetch_if.stall) begin
                        pc_d = pc_q + XLEN'(4);
                    end
                    if (state_q == FLUSH) begin
                        flushCnt_d = flushCnt_q - 3'd1;
                        if (flushCnt_q == 3'd1) begin
                            flush_d = 1'b0;
                            state_d = RUN;
                        end
                    end
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= BOOT;
            pc_q       <= RESET_VECTOR;
            valid_q    <= 1'b0;
            flush_q    <= 1'b0;
            flushCnt_q <= 3'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            flush_q    <= flush_d;
            flushCnt_q <= flushCnt_d;
        end
    end

    assign fetch_if.pc_out    = pc_q;
    assign fetch_if.valid_out = valid_q;
    assign fetch_if.flush_out = flush_q;

endmodule
